// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit seven-segment scan driver
//
// Purpose: latches a packed multi-digit value and scans it one digit per slot
// onto a shared active-low segment bus, with leading-zero blanking, optional
// hex glyphs, decimal points, anti-ghosting dead time and frame-synchronous
// (tear-free) updates of the displayed value.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   bcd_in  packed digits, digit 0 in bits [3:0] (least significant)
//   dp_in   decimal point request per digit, 1 = lit
//   load    single-cycle strobe capturing bcd_in/dp_in into the pending regs
//   seg7    segments a..g on bits 6..0, 0 = lit
//   dp      decimal point, 0 = lit
//   an      digit enables, 0 = digit on
//   frame   one-cycle pulse when the scan wraps back to digit 0
module seg7_scan_driver #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int HEX_MODE  = 0,
    parameter int BLANK_LZ  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic [6:0]            seg7,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] pend_val;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [4*N_DIGITS-1:0] act_val;
    logic [N_DIGITS-1:0]   act_dp;

    logic tick;
    logic wrap;
    logic dead;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Dead time is compiled out entirely when disabled so no constant compare remains.
    generate
        if (BLANK_CYC > 0) begin : g_dead
            assign dead = (cnt < CW'(BLANK_CYC));
        end else begin : g_no_dead
            assign dead = 1'b0;
        end
    endgenerate

    // Prescaler and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending regs collect loads at any time; active regs move only at the
    // frame boundary. A load coinciding with the wrap goes straight through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val <= '0;
            pend_dp  <= '0;
            act_val  <= '0;
            act_dp   <= '0;
        end else begin
            if (load) begin
                pend_val <= bcd_in;
                pend_dp  <= dp_in;
            end
            if (wrap) begin
                act_val <= load ? bcd_in : pend_val;
                act_dp  <= load ? dp_in  : pend_dp;
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b1100000;
            4'd12:   s = 7'b0110001;
            4'd13:   s = 7'b1000010;
            4'd14:   s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (HEX_MODE == 0 && code > 4'd9) begin
            s = 7'b1111111;
        end
        return s;
    endfunction

    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_blank;
    logic                zero_run;
    logic [N_DIGITS-1:0] an_next;
    logic [6:0]          seg_next;

    // Walk from the most significant digit down so zero_run tells whether the
    // digit and everything above it is zero (leading-zero suppression).
    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        an_next   = '1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_val[4*i +: 4] == 4'd0);
            if (idx == IW'(i)) begin
                cur_code  = act_val[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blank = (BLANK_LZ != 0) && (i > 0) && zero_run;
                if (!dead) begin
                    an_next[i] = 1'b0;
                end
            end
        end
    end

    assign seg_next = cur_blank ? 7'b1111111 : seg_decode(cur_code);

    // Registered outputs: one cycle behind (idx, cnt, active).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg7  <= 7'h7F;
            dp    <= 1'b1;
            an    <= '1;
            frame <= 1'b0;
        end else begin
            seg7  <= seg_next;
            dp    <= ~cur_dp;
            an    <= an_next;
            frame <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0] seg7_h, seg7_d;
    logic       dp_h, dp_d, frame_h, frame_d;
    logic [3:0] an_h, an_d;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: k counts clock edges since reset release.
    int          k = 0;
    logic [15:0] m_pend = '0, m_act = '0;
    logic [3:0]  m_pdp = '0, m_adp = '0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .HEX_MODE(1), .BLANK_LZ(1)) dut_hex (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .seg7(seg7_h), .dp(dp_h), .an(an_h), .frame(frame_h)
    );

    seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .HEX_MODE(0), .BLANK_LZ(1)) dut_dec (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .seg7(seg7_d), .dp(dp_d), .an(an_d), .frame(frame_d)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Glyph shown for digit i of value v, derived from the display rules.
    function automatic logic [6:0] pat(input logic [15:0] v, input int i, input bit hex);
        int code;
        int upper;
        code  = (v >> (4 * i)) & 15;
        upper = v >> (4 * i);
        if (i > 0 && upper == 0) return 7'h7F;
        case (code)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: ;
        endcase
        if (!hex) return 7'h7F;
        case (code)
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic model_reset();
        k = 0;
        m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    endtask

    // One clock: predict outputs from the slot position and active value,
    // apply load/frame rules, then compare on the falling edge.
    task automatic cycle();
        int         slot_cyc;
        int         ix;
        logic [3:0] e_an;
        logic [6:0] e_sh, e_sd;
        logic       e_dp, e_fr;
        slot_cyc = k % 4;
        ix       = (k / 4) % 4;
        e_an     = (slot_cyc < 1) ? 4'hF : ~(4'b0001 << ix);
        e_sh     = pat(m_act, ix, 1'b1);
        e_sd     = pat(m_act, ix, 1'b0);
        e_dp     = ~m_adp[ix];
        e_fr     = (k % 16 == 15);
        if (load) begin
            m_pend = bcd_in;
            m_pdp  = dp_in;
        end
        if (k % 16 == 15) begin
            m_act = m_pend;
            m_adp = m_pdp;
        end
        @(posedge clk);
        @(negedge clk);
        chk("an_hex",    16'(an_h),    16'(e_an));
        chk("an_dec",    16'(an_d),    16'(e_an));
        chk("seg7_hex",  16'(seg7_h),  16'(e_sh));
        chk("seg7_dec",  16'(seg7_d),  16'(e_sd));
        chk("dp_hex",    16'(dp_h),    16'(e_dp));
        chk("dp_dec",    16'(dp_d),    16'(e_dp));
        chk("frame_hex", 16'(frame_h), 16'(e_fr));
        chk("frame_dec", 16'(frame_d), 16'(e_fr));
        k++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_cyc(input logic [15:0] v, input logic [3:0] d);
        bcd_in = v;
        dp_in  = d;
        load   = 1'b1;
        cycle();
        load   = 1'b0;
    endtask

    // Advance until the next edge is at the given frame phase (at most 16 cycles).
    task automatic go_phase(input int ph);
        for (int i = 0; i < 16 && (k % 16) != ph; i++) cycle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an_hex"},    16'(an_h),    16'hF);
        chk({tag, "_an_dec"},    16'(an_d),    16'hF);
        chk({tag, "_seg7_hex"},  16'(seg7_h),  16'h7F);
        chk({tag, "_seg7_dec"},  16'(seg7_d),  16'h7F);
        chk({tag, "_dp_hex"},    16'(dp_h),    16'h1);
        chk({tag, "_frame_hex"}, 16'(frame_h), 16'h0);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        model_reset();

        // 1: idle scan of value 0.
        cycles(32);

        // 2: load mid-frame, held until the frame boundary.
        go_phase(5);
        load_cyc(16'h0205, 4'b0000);
        cycles(40);

        // 3: hex glyphs versus blanked codes.
        load_cyc(16'hAF3C, 4'b0000);
        cycles(36);

        // 4: load on the wrap tick, then two loads within one frame.
        go_phase(15);
        load_cyc(16'h0001, 4'b0000);
        cycles(16);
        go_phase(2);
        load_cyc(16'h0011, 4'b0000);
        go_phase(8);
        load_cyc(16'h0022, 4'b0000);
        cycles(36);

        // 5: decimal point on a blanked digit.
        load_cyc(16'h0000, 4'b0100);
        cycles(36);

        // 6: asynchronous reset during digit 2's slot.
        go_phase(10);
        chk("pre_reset_an", 16'(an_h), 16'hB);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycles(32);

        // Randomized loads at random times.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) load_cyc(16'($urandom), 4'($urandom));
            else cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
